phase_tracker: RTL and testbench
================================

PHASE_TRACKER -- requirements
Module: phase_tracker

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, meaning DFT size is 2**ADDR_WIDTH points.
REQ-002 The block SHALL have parameter PHASE_WIDTH, default 24, meaning signed phase word width, where full scale ±2**(PHASE_WIDTH-1) = ±pi.
REQ-003 The block SHALL have parameter HALF_SPECTRUM, default 1, meaning only store bins with index MSB clear (1) or store all bins (0).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port phase_tdata, input, PHASE_WIDTH bits: phase of the incoming bin.
REQ-007 The block SHALL have port phase_tvalid, input, 1 bit: phase_tdata/phase_tuser valid this cycle (no backpressure; sink always ready).
REQ-008 The block SHALL have port phase_tlast, input, 1 bit: qualified by phase_tvalid, marks the last bin of a frame.
REQ-009 The block SHALL have port phase_tuser, input, ADDR_WIDTH bits: bin index of phase_tdata.
REQ-010 The block SHALL have port query_bin, input, ADDR_WIDTH bits: bin to look up.
REQ-011 The block SHALL have port query_valid, input, 1 bit: query request.
REQ-012 The block SHALL have port query_ready, output, 1 bit: query accepted when query_valid & query_ready.
REQ-013 The block SHALL have port phase, output, PHASE_WIDTH bits: phase of query_bin in the newest completed frame.
REQ-014 The block SHALL have port phase_last, output, PHASE_WIDTH bits: phase of query_bin in the frame before that.
REQ-015 The block SHALL have port phase_delta, output, PHASE_WIDTH bits: (phase - phase_last) mod 2**PHASE_WIDTH, i.e. the principal value in [-pi, pi).
REQ-016 The block SHALL have port last_valid, output, 1 bit: phase_last/phase_delta are meaningful (two frames complete).
REQ-017 The block SHALL have port phases_valid, output, 1 bit: output strobe, one cycle per accepted query.

Function
REQ-018 Storage SHALL be three banks of DEPTH words, each PHASE_WIDTH bits, with DEPTH = 2**(ADDR_WIDTH-1) if HALF_SPECTRUM else 2**ADDR_WIDTH.
REQ-019 Bank roles SHALL be WRITE, CUR and PREV, held in a 3-state rotation register.
REQ-020 A write SHALL occur when phase_tvalid is high and, with HALF_SPECTRUM=1, phase_tuser MSB is 0; the address is phase_tuser[log2(DEPTH)-1:0] into the WRITE bank; beats with MSB set are dropped.
REQ-021 On phase_tvalid & phase_tlast the roles SHALL rotate on the next edge: WRITE becomes CUR, CUR becomes PREV, PREV becomes WRITE.
REQ-022 The tlast beat's own data SHALL be written before the rotation takes effect.
REQ-023 frames_done SHALL be a saturating 2-bit counter that increments on each tlast.
REQ-024 query_ready SHALL be 1 iff frames_done >= 1.
REQ-025 last_valid SHALL be 1 iff frames_done = 2, sampled at query acceptance.
REQ-026 Query latency SHALL be fixed: an accepted query at cycle N yields phases_valid=1 with phase/phase_last at N+2 (registered read N+1, output register N+2) and phase_delta at N+2.
REQ-027 Back-to-back queries SHALL be accepted every cycle at full throughput, with no output backpressure.
REQ-028 A query index with HALF_SPECTRUM=1 and MSB set SHALL read bin (DEPTH*2 - query_bin) mod DEPTH*2; i.e. the mirrored bin, with phase, phase_last and phase_delta negated (conjugate symmetry).
REQ-029 When tlast and a query coincide, the query SHALL read the banks as assigned before the rotation.
REQ-030 A read and a write to the same physical bank SHALL be impossible by construction.
REQ-031 When last_valid=0, phase_last SHALL be 0 and phase_delta SHALL equal phase.
REQ-032 When phases_valid=0, phase, phase_last and phase_delta SHALL hold their previous values.

Reset
REQ-033 Asserting reset_n=0 SHALL asynchronously clear the rotation register (WRITE=0, CUR=1, PREV=2), frames_done, the read pipeline valids, phases_valid, phase, phase_last, phase_delta and last_valid to 0.
REQ-034 As a consequence of REQ-033, query_ready SHALL be 0 during and after reset.
REQ-035 A partial frame in progress at reset SHALL be discarded.
REQ-036 RAM contents SHALL not be cleared by reset and are never observable before being written in the relevant frame.

Structure
REQ-037 A shared package phase_pkg SHALL hold the bank-role encoding constants and the DEPTH/index-width calculation functions.
REQ-038 One sub-module, phase_bank_ram, SHALL be instantiated three times: an inferred simple dual-port RAM (1 write port, 1 registered read port, 1-cycle latency) parameterised by depth and width.

Verification
REQ-039 The bench SHALL cover single frame: write bins 0..1023 with phase=bin*16, tlast on 1023, then query 5 -> at N+2 phase=80, last_valid=0, phase_last=0, phase_delta=80.
REQ-040 The bench SHALL cover two frames: frame1 bin 7=0x7FFF00, frame2 bin 7=0x800100, then query 7 -> phase=0x800100, phase_last=0x7FFF00, phase_delta=0x000200 (wrap across ±pi), last_valid=1.
REQ-041 The bench SHALL cover three frames: frames with bin 3 = 10, 20, 35, then query 3 -> phase=35, phase_last=20, phase_delta=15 (PREV bank correctly recycled).
REQ-042 The bench SHALL cover coincident events: query bin 2 in the same cycle as frame2 tlast -> returns frame1 values (last_valid=0), and a query on the next cycle returns frame2 values with last_valid=1.
REQ-043 The bench SHALL cover mirrored bins: with HALF_SPECTRUM=1, drop beats with tuser=1030; query 2046 -> phase equals negated bin 2 value.
REQ-044 The bench SHALL cover reset mid-frame: pulse reset_n low at bin 500 of frame3 -> query_ready=0 immediately; outputs are 0; after a fresh full frame, query_ready=1 and last_valid=0.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared definitions for the phase tracker: bank-role rotation encoding
// and bank geometry helpers.
package phase_pkg;

   typedef logic [1:0] bank_sel_t;

   localparam int unsigned NUM_BANKS = 3;

   localparam bank_sel_t BANK0 = 2'd0;
   localparam bank_sel_t BANK1 = 2'd1;
   localparam bank_sel_t BANK2 = 2'd2;

   localparam logic [1:0] FRAMES_FULL = 2'd2;

   // Each rotation state fixes which physical bank plays WRITE, CUR and PREV.
   typedef enum logic [1:0] {
      ROT_A = 2'd0,   // WRITE=0 CUR=1 PREV=2
      ROT_B = 2'd1,   // WRITE=2 CUR=0 PREV=1
      ROT_C = 2'd2    // WRITE=1 CUR=2 PREV=0
   } rot_t;

   function automatic int unsigned bank_depth(input int addr_width, input int half);
      return (half != 0) ? (32'd1 << (addr_width - 1)) : (32'd1 << addr_width);
   endfunction

   function automatic int unsigned bank_idx_width(input int addr_width, input int half);
      return (half != 0) ? 32'(addr_width - 1) : 32'(addr_width);
   endfunction

   function automatic bank_sel_t write_bank(input rot_t rot);
      case (rot)
         ROT_B:   return BANK2;
         ROT_C:   return BANK1;
         default: return BANK0;
      endcase
   endfunction

   function automatic bank_sel_t cur_bank(input rot_t rot);
      case (rot)
         ROT_B:   return BANK0;
         ROT_C:   return BANK2;
         default: return BANK1;
      endcase
   endfunction

   function automatic bank_sel_t prev_bank(input rot_t rot);
      case (rot)
         ROT_B:   return BANK1;
         ROT_C:   return BANK0;
         default: return BANK2;
      endcase
   endfunction

   function automatic rot_t rot_advance(input rot_t rot);
      case (rot)
         ROT_A:   return ROT_B;
         ROT_B:   return ROT_C;
         default: return ROT_A;
      endcase
   endfunction

endpackage

// File: rtl/phase_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port with
// single-cycle latency. Contents are not reset.
module phase_bank_ram #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WIDTH = 24,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             write_en,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic             read_en,
   input  logic [AW-1:0]    read_addr,
   output logic [WIDTH-1:0] read_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (write_en) begin
         mem[write_addr] <= write_data;
      end
      if (read_en) begin
         read_data <= mem[read_addr];
      end
   end

endmodule

// File: rtl/phase_tracker.sv
// Phase tracker: keeps per-bin phase of the two newest complete frames in
// three rotating banks and answers bin queries with phase, previous phase and delta.
module phase_tracker
   import phase_pkg::*;
#(
   parameter int ADDR_WIDTH    = 11,
   parameter int PHASE_WIDTH   = 24,
   parameter int HALF_SPECTRUM = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [PHASE_WIDTH-1:0] phase_tdata,
   input  logic                   phase_tvalid,
   input  logic                   phase_tlast,
   input  logic [ADDR_WIDTH-1:0]  phase_tuser,
   input  logic [ADDR_WIDTH-1:0]  query_bin,
   input  logic                   query_valid,
   output logic                   query_ready,
   output logic [PHASE_WIDTH-1:0] phase,
   output logic [PHASE_WIDTH-1:0] phase_last,
   output logic [PHASE_WIDTH-1:0] phase_delta,
   output logic                   last_valid,
   output logic                   phases_valid
);

   localparam int unsigned DEPTH = bank_depth(ADDR_WIDTH, HALF_SPECTRUM);
   localparam int unsigned IDX_W = bank_idx_width(ADDR_WIDTH, HALF_SPECTRUM);

   rot_t       rot, rot_next;
   logic [1:0] frames_done, frames_next;
   logic       frame_end;

   assign frame_end   = phase_tvalid & phase_tlast;
   assign query_ready = (frames_done != 2'd0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rot         <= ROT_A;
         frames_done <= '0;
      end else begin
         rot         <= rot_next;
         frames_done <= frames_next;
      end
   end

   always_comb begin
      rot_next    = rot;
      frames_next = frames_done;
      if (frame_end) begin
         rot_next = rot_advance(rot);
         if (frames_done < FRAMES_FULL) begin
            frames_next = frames_done + 2'd1;
         end
      end
   end

   logic             bin_stored;
   logic             write_en;
   logic             query_accept;
   logic             query_mirrored;
   logic [IDX_W-1:0] read_idx;

   // Upper-half bins of a real-input spectrum are conjugates of the lower half.
   always_comb begin
      bin_stored     = 1'b1;
      query_mirrored = 1'b0;
      if (HALF_SPECTRUM != 0) begin
         bin_stored     = ~phase_tuser[ADDR_WIDTH-1];
         query_mirrored = query_bin[ADDR_WIDTH-1];
      end
      read_idx = query_mirrored ? (-query_bin[IDX_W-1:0]) : query_bin[IDX_W-1:0];
   end

   assign write_en     = phase_tvalid & bin_stored;
   assign query_accept = query_valid & query_ready;

   bank_sel_t wr_sel;
   assign wr_sel = write_bank(rot);

   logic [NUM_BANKS-1:0][PHASE_WIDTH-1:0] rd_data;

   // The WRITE bank is never read, so read/write collisions cannot happen.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic bank_we;
      logic bank_re;

      assign bank_we = write_en & (wr_sel == bank_sel_t'(b));
      assign bank_re = query_accept & (wr_sel != bank_sel_t'(b));

      phase_bank_ram #(
         .DEPTH (DEPTH),
         .WIDTH (PHASE_WIDTH)
      ) u_ram (
         .clock      (clock),
         .write_en   (bank_we),
         .write_addr (phase_tuser[IDX_W-1:0]),
         .write_data (phase_tdata),
         .read_en    (bank_re),
         .read_addr  (read_idx),
         .read_data  (rd_data[b])
      );
   end

   logic s1_valid;
   logic s1_mirror;
   logic s1_last;
   rot_t s1_rot;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_mirror <= 1'b0;
         s1_last   <= 1'b0;
         s1_rot    <= ROT_A;
      end else begin
         s1_valid <= query_accept;
         if (query_accept) begin
            s1_rot    <= rot;
            s1_mirror <= query_mirrored;
            s1_last   <= (frames_done == FRAMES_FULL);
         end
      end
   end

   logic [PHASE_WIDTH-1:0] cur_word, prev_word, diff_word;
   logic [PHASE_WIDTH-1:0] out_phase, out_last, out_delta;

   always_comb begin
      cur_word  = rd_data[cur_bank(s1_rot)];
      prev_word = s1_last ? rd_data[prev_bank(s1_rot)] : '0;
      diff_word = cur_word - prev_word;
      out_phase = cur_word;
      out_last  = prev_word;
      out_delta = diff_word;
      if (s1_mirror) begin
         out_phase = -cur_word;
         out_last  = -prev_word;
         out_delta = -diff_word;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phases_valid <= 1'b0;
         phase        <= '0;
         phase_last   <= '0;
         phase_delta  <= '0;
         last_valid   <= 1'b0;
      end else begin
         phases_valid <= s1_valid;
         if (s1_valid) begin
            phase       <= out_phase;
            phase_last  <= out_last;
            phase_delta <= out_delta;
            last_valid  <= s1_last;
         end
      end
   end

endmodule

// File: tb/tb_phase_tracker.sv
// Scoreboard bench for phase_tracker: directed frames and queries push expected
// responses; a monitor pops and compares on every phases_valid strobe.
module tb_phase_tracker;

   localparam int AW = 11;
   localparam int PW = 24;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [PW-1:0] phase_tdata;
   logic          phase_tvalid;
   logic          phase_tlast;
   logic [AW-1:0] phase_tuser;
   logic [AW-1:0] query_bin;
   logic          query_valid;
   logic          query_ready;
   logic [PW-1:0] phase;
   logic [PW-1:0] phase_last;
   logic [PW-1:0] phase_delta;
   logic          last_valid;
   logic          phases_valid;

   phase_tracker #(
      .ADDR_WIDTH    (AW),
      .PHASE_WIDTH   (PW),
      .HALF_SPECTRUM (1)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .phase_tdata  (phase_tdata),
      .phase_tvalid (phase_tvalid),
      .phase_tlast  (phase_tlast),
      .phase_tuser  (phase_tuser),
      .query_bin    (query_bin),
      .query_valid  (query_valid),
      .query_ready  (query_ready),
      .phase        (phase),
      .phase_last   (phase_last),
      .phase_delta  (phase_delta),
      .last_valid   (last_valid),
      .phases_valid (phases_valid)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [PW-1:0] ph;
      logic [PW-1:0] pl;
      logic [PW-1:0] pd;
      logic          lv;
      int            due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n && phases_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'(phases_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("latency",     32'(cyc),         32'(mon_e.due));
            check("phase",       32'(phase),       32'(mon_e.ph));
            check("phase_last",  32'(phase_last),  32'(mon_e.pl));
            check("phase_delta", 32'(phase_delta), 32'(mon_e.pd));
            check("last_valid",  32'(last_valid),  32'(mon_e.lv));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      phase_tvalid = 1'b0;
      phase_tlast  = 1'b0;
      query_valid  = 1'b0;
   endtask

   task automatic send_beat(input logic [AW-1:0] bin, input logic [PW-1:0] d, input logic last);
      phase_tvalid = 1'b1;
      phase_tlast  = last;
      phase_tuser  = bin;
      phase_tdata  = d;
      tick();
   endtask

   task automatic post_query(input logic [AW-1:0] bin, input logic [PW-1:0] ph,
                             input logic [PW-1:0] pl, input logic [PW-1:0] pd, input logic lv);
      query_valid = 1'b1;
      query_bin   = bin;
      exp_q.push_back('{ph, pl, pd, lv, cyc + 2});
   endtask

   task automatic query(input logic [AW-1:0] bin, input logic [PW-1:0] ph,
                        input logic [PW-1:0] pl, input logic [PW-1:0] pd, input logic lv);
      post_query(bin, ph, pl, pd, lv);
      tick();
   endtask

   task automatic drain();
      for (int i = 0; i < 16 && exp_q.size() != 0; i++) @(posedge clock);
      #1;
      check("responses_outstanding", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_query_ready"},  32'(query_ready),  32'd0);
      check({tag, "_phases_valid"}, 32'(phases_valid), 32'd0);
      check({tag, "_phase"},        32'(phase),        32'd0);
      check({tag, "_phase_last"},   32'(phase_last),   32'd0);
      check({tag, "_phase_delta"},  32'(phase_delta),  32'd0);
      check({tag, "_last_valid"},   32'(last_valid),   32'd0);
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n      = 1'b0;
      phase_tdata  = '0;
      phase_tvalid = 1'b0;
      phase_tlast  = 1'b0;
      phase_tuser  = '0;
      query_bin    = '0;
      query_valid  = 1'b0;
      #2;
      check_cleared("reset");
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      check("ready_no_frames", 32'(query_ready), 32'd0);

      // Not ready yet: this request must produce no strobe.
      query_valid = 1'b1;
      query_bin   = 11'd5;
      tick();

      for (int b = 0; b < 1024; b++) send_beat(11'(b), 24'(b * 16), (b == 1023));
      check("ready_one_frame", 32'(query_ready), 32'd1);
      query(11'd5,    24'd80,      24'd0, 24'd80,      1'b0);
      query(11'd0,    24'd0,       24'd0, 24'd0,       1'b0);
      query(11'd1023, 24'h003FF0,  24'd0, 24'h003FF0,  1'b0);
      query(11'd2046, 24'hFFFFE0,  24'd0, 24'hFFFFE0,  1'b0);

      send_beat(11'd7, 24'h7FFF00, 1'b0);
      send_beat(11'd3, 24'd10,     1'b0);
      phase_tvalid = 1'b1;
      phase_tlast  = 1'b1;
      phase_tuser  = 11'd2;
      phase_tdata  = 24'h000100;
      post_query(11'd2, 24'h000020, 24'd0, 24'h000020, 1'b0);
      tick();
      query(11'd2, 24'h000100, 24'h000020, 24'h0000E0, 1'b1);
      query(11'd7, 24'h7FFF00, 24'h000070, 24'h7FFE90, 1'b1);

      send_beat(11'd7, 24'h800100, 1'b0);
      send_beat(11'd3, 24'd20,     1'b0);
      send_beat(11'd6, 24'h000060, 1'b0);
      send_beat(11'd2, 24'h000200, 1'b1);
      query(11'd7, 24'h800100, 24'h7FFF00, 24'h000200, 1'b1);
      query(11'd3, 24'd20,     24'd10,     24'd10,     1'b1);

      send_beat(11'd3,    24'd35,     1'b0);
      send_beat(11'd6,    24'h000066, 1'b0);
      send_beat(11'd1030, 24'h123456, 1'b0);
      send_beat(11'd2,    24'h000500, 1'b1);
      query(11'd3,    24'd35,     24'd20,     24'd15,     1'b1);
      query(11'd6,    24'h000066, 24'h000060, 24'h000006, 1'b1);
      query(11'd2046, 24'hFFFB00, 24'hFFFE00, 24'hFFFD00, 1'b1);
      query(11'd2042, 24'hFFFF9A, 24'hFFFFA0, 24'hFFFFFA, 1'b1);
      drain();

      for (int b = 0; b < 500; b++) send_beat(11'(b), 24'h0ABCDE, 1'b0);
      phase_tvalid = 1'b1;
      phase_tuser  = 11'd500;
      phase_tdata  = 24'h0ABCDE;
      #1;
      reset_n = 1'b0;
      #1;
      check_cleared("midframe_reset");
      phase_tvalid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      check("ready_after_reset", 32'(query_ready), 32'd0);

      for (int b = 0; b < 1024; b++) send_beat(11'(b), 24'(b * 3), (b == 1023));
      check("ready_fresh_frame", 32'(query_ready), 32'd1);
      query(11'd5,    24'd15,   24'd0, 24'd15,   1'b0);
      query(11'd500,  24'd1500, 24'd0, 24'd1500, 1'b0);
      query(11'd1023, 24'd3069, 24'd0, 24'd3069, 1'b0);
      drain();

      repeat (4) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
